// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared constants, entry layout and result-state encoding for alu_op_sequencer
package alu_seq_pkg;

  localparam int DW_DEF = 4;
  localparam int SW_DEF = 3;

  // Queued request layout, MSB first: {a, b, sel}
  typedef struct packed {
    logic [DW_DEF-1:0] a;
    logic [DW_DEF-1:0] b;
    logic [SW_DEF-1:0] sel;
  } entry_t;

  localparam int ENTRY_W_DEF = $bits(entry_t);

  typedef enum logic {
    RES_EMPTY = 1'b0,
    RES_FULL  = 1'b1
  } res_state_e;

  function automatic int entry_w(input int dw, input int sw);
    return 2 * dw + sw;
  endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// rtl/alu_seq_fifo.sv - synchronous request FIFO with occupancy count
module alu_seq_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 11,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  localparam logic [AW:0]   C_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_ONE     = (AW+1)'(1);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == C_FULL);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - queues ALU requests and registers one result per cycle
// Optional op counter output enabled by ALU_SEQ_STATS_EN.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = DW_DEF,
  parameter int SW    = SW_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_a,
  input  logic [DW-1:0]            in_b,
  input  logic [SW-1:0]            in_sel,
  output logic [DW-1:0]            alu_a,
  output logic [DW-1:0]            alu_b,
  output logic [SW-1:0]            alu_sel,
  input  logic [DW:0]              alu_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DW:0]              res_data,
  output logic [SW-1:0]            res_sel,
`ifdef ALU_SEQ_STATS_EN
  output logic [15:0]              op_count,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int ENTRY_W = entry_w(DW, SW);

  logic [ENTRY_W-1:0]      w_push_data;
  logic [ENTRY_W-1:0]      w_head;
  logic [DW-1:0]           w_head_a;
  logic [DW-1:0]           w_head_b;
  logic [SW-1:0]           w_head_sel;
  logic                    w_full;
  logic                    w_empty;
  logic [$clog2(DEPTH):0]  w_count;
  logic                    w_issue;
  res_state_e              r_state;
  res_state_e              w_state_nxt;
  logic [DW:0]             r_res_data;
  logic [SW-1:0]           r_res_sel;

  assign w_push_data = {in_a, in_b, in_sel};

  alu_seq_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_push  (in_valid),
    .i_data  (w_push_data),
    .i_pop   (w_issue),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_head_a   = w_head[ENTRY_W-1 -: DW];
  assign w_head_b   = w_head[SW +: DW];
  assign w_head_sel = w_head[SW-1:0];

  // Mask the head when empty so the ALU never sees stale storage.
  assign alu_a   = w_empty ? '0 : w_head_a;
  assign alu_b   = w_empty ? '0 : w_head_b;
  assign alu_sel = w_empty ? '0 : w_head_sel;

  // in_ready comes from the registered count only; no pop-through when full.
  assign in_ready  = !w_full;
  assign count     = w_count;
  assign res_valid = (r_state == RES_FULL);
  assign res_data  = r_res_data;
  assign res_sel   = r_res_sel;
  assign w_issue   = !w_empty && (!res_valid || res_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RES_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RES_EMPTY: begin
        if (w_issue) begin
          w_state_nxt = RES_FULL;
        end
      end
      RES_FULL: begin
        if (w_issue) begin
          w_state_nxt = RES_FULL;
        end else if (res_ready) begin
          w_state_nxt = RES_EMPTY;
        end
      end
      default: w_state_nxt = RES_EMPTY;
    endcase
  end

  // Result data holds its last value when drained without a new issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_data <= '0;
      r_res_sel  <= '0;
    end else if (w_issue) begin
      r_res_data <= alu_out;
      r_res_sel  <= alu_sel;
    end
  end

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] r_op_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (w_issue && (r_op_count != 16'hFFFF)) begin
      r_op_count <= r_op_count + 16'd1;
    end
  end

  assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer with queue-based reference model
module tb_alu_op_sequencer;

  localparam int DEPTH = 4;
  localparam int DW    = 4;
  localparam int SW    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic [SW-1:0] in_sel = '0;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [SW-1:0] alu_sel;
  logic [DW:0]   alu_out;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW:0]   res_data;
  logic [SW-1:0] res_sel;
  logic [2:0]    count;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0]   op_count;
`endif

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic [10:0] mq[$];
  logic        m_valid = 1'b0;
  logic [4:0]  m_data = '0;
  logic [2:0]  m_sel = '0;
  int          m_ops = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DEPTH(DEPTH), .DW(DW), .SW(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sel    (in_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_sel   (res_sel),
`ifdef ALU_SEQ_STATS_EN
    .op_count  (op_count),
`endif
    .count     (count)
  );

  function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
    case (s)
      3'd0:    return {1'b0, a & b};
      3'd1:    return {1'b0, a} + {1'b0, b};
      3'd2:    return {1'b0, a} - {1'b0, b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~a};
      3'd6:    return {a, 1'b0};
      default: return {2'b00, a[3:1]};
    endcase
  endfunction

  assign alu_out = alu_ref(alu_a, alu_b, alu_sel);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a queue of requests plus one result slot, updated per edge.
  initial begin
    forever begin
      int          sz;
      bit          do_issue;
      bit          do_push;
      logic [10:0] e;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = '0;
        m_ops   = 0;
      end else begin
        sz       = mq.size();
        do_issue = (sz > 0) && (!m_valid || res_ready);
        do_push  = in_valid && (sz < DEPTH);
        if (do_issue) begin
          e       = mq.pop_front();
          m_data  = alu_ref(e[10:7], e[6:3], e[2:0]);
          m_sel   = e[2:0];
          m_valid = 1'b1;
          if (m_ops < 65535) m_ops++;
        end else if (res_ready) begin
          m_valid = 1'b0;
        end
        if (do_push) mq.push_back({in_a, in_b, in_sel});
      end
    end
  end

  initial begin
    forever begin
      logic [10:0] h;
      @(negedge clk);
      if (chk_en) begin
        h = (mq.size() > 0) ? mq[0] : 11'd0;
        chk("count",     32'(count),     32'(mq.size()));
        chk("in_ready",  32'(in_ready),  32'(mq.size() < DEPTH));
        chk("res_valid", 32'(res_valid), 32'(m_valid));
        chk("res_data",  32'(res_data),  32'(m_data));
        chk("res_sel",   32'(res_sel),   32'(m_sel));
        chk("alu_a",     32'(alu_a),     32'(h[10:7]));
        chk("alu_b",     32'(alu_b),     32'(h[6:3]));
        chk("alu_sel",   32'(alu_sel),   32'(h[2:0]));
`ifdef ALU_SEQ_STATS_EN
        chk("op_count",  32'(op_count),  32'(m_ops));
`endif
      end
    end
  end

  task automatic step(input bit v, input logic [3:0] a, input logic [3:0] b, input logic [2:0] s, input bit rr);
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_sel    = s;
    res_ready = rr;
  endtask

  initial begin
    int max_cnt;
    int nres;

    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data",  32'(res_data),  32'd0);
    chk("rst_res_sel",   32'(res_sel),   32'd0);
    chk("rst_alu",       32'({alu_a, alu_b, alu_sel}), 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Single op: 3 + 2 -> 5
    step(1, 4'd3, 4'd2, 3'b001, 1);
    step(0, 0, 0, 0, 1);
    chk("single_alu_sel",  32'(alu_sel),   32'b001);
    chk("single_alu_a",    32'(alu_a),     32'd3);
    chk("single_pre_valid", 32'(res_valid), 32'd0);
    step(0, 0, 0, 0, 1);
    chk("single_res_valid", 32'(res_valid), 32'd1);
    chk("single_res_data",  32'(res_data),  32'b00101);
    chk("single_res_sel",   32'(res_sel),   32'b001);
    step(0, 0, 0, 0, 1);

    // Back-to-back, one op per cycle
    max_cnt = 0;
    nres = 0;
    for (int s = 0; s < 8; s++) begin
      step(1, 4'd3, 4'd2, 3'(s), 1);
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (res_valid) nres++;
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1);
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (res_valid) nres++;
    end
    chk("b2b_max_count", 32'(max_cnt), 32'd1);
    chk("b2b_results",   32'(nres),    32'd8);

    // Backpressure until full
    for (int i = 0; i < 6; i++) begin
      step(1, 4'($urandom_range(15)), 4'($urandom_range(15)), 3'($urandom_range(7)), 0);
      if (i == 5) begin
        chk("bp_in_ready_5", 32'(in_ready), 32'd0);
        chk("bp_count_5",    32'(count),    32'd4);
      end
    end
    step(0, 0, 0, 0, 0);
    chk("bp_6th_rejected", 32'(count),     32'd4);
    chk("bp_held",         32'(res_valid), 32'd1);
    nres = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 1);
      if (res_valid) nres++;
    end
    chk("bp_drain_results", 32'(nres), 32'd5);

    // Steady push/pop at count=2 across the wrap boundary
    for (int i = 0; i < 3; i++) step(1, 4'(i + 5), 4'(i), 3'(i), 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 4'($urandom_range(15)), 4'($urandom_range(15)), 3'($urandom_range(7)), 1);
      chk("pp_count", 32'(count), 32'd2);
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 4; i++) step(1, 4'(i + 1), 4'(i + 9), 3'(i + 2), 0);
    step(0, 0, 0, 0, 0);
    chk("mid_pre_count", 32'(count), 32'd3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_count",     32'(count),     32'd0);
    chk("mid_res_valid", 32'(res_valid), 32'd0);
    chk("mid_in_ready",  32'(in_ready),  32'd1);
    chk("mid_alu_sel",   32'(alu_sel),   32'd0);
    chk("mid_res_data",  32'(res_data),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef ALU_SEQ_STATS_EN
    for (int i = 0; i < 20; i++) step(1, 4'(i), 4'(i), 3'(i), 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    chk("op_count_20", 32'(op_count), 32'd20);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(1)), 4'($urandom_range(15)), 4'($urandom_range(15)),
           3'($urandom_range(7)), ($urandom_range(3) != 0));
    end
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
    chk("final_empty", 32'(count), 32'd0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
